operand_fetch: RTL and testbench

Parametrised decode/operand-fetch pipeline stage for the CPU core, replacing the fixed 32-bit, 16-register, always-advancing decode register. It resolves the A/B operands from the register file, PC, overflow register or immediate, and adds write-back bypass. A valid/ready handshake with a 2-entry skid buffer lets the downstream execute stage stall. A flush input supports branch recovery. It sits between instruction fetch/field split and execute.

---
 rtl/operand_fetch_pkg.sv | 43 ++++
 rtl/operand_fetch_if.sv | 48 ++++
 rtl/operand_fetch_sel.sv | 66 ++++++
 rtl/operand_fetch.sv | 120 ++++++++++++
 tb/tb_operand_fetch.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared decode-stage types: special register indices, the held operand bundle and its refresh helper.
package operand_fetch_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREG  = 16;
  localparam int unsigned RW    = $clog2(NREG);
  localparam int unsigned IMMW  = 14;
  localparam int unsigned OPCW  = 5;
  localparam int unsigned CONDW = 3;

  function automatic int unsigned idx_pc(input int unsigned n);
    return n - 2;
  endfunction

  function automatic int unsigned idx_ovf(input int unsigned n);
    return n - 1;
  endfunction

  typedef struct packed {
    logic [XLEN-1:0]  aval;
    logic [XLEN-1:0]  bval;
    logic [RW-1:0]    a_tag;
    logic             a_tag_v;
    logic [RW-1:0]    b_tag;
    logic             b_tag_v;
    logic [OPCW-1:0]  opc;
    logic [RW-1:0]    rc;
    logic [CONDW-1:0] cond;
    logic             cmp;
  } op_bundle_t;

  // Keep a stalled bundle coherent with a same-cycle register-file write.
  function automatic op_bundle_t refresh(input op_bundle_t b, input logic v,
                                         input logic wb_en, input logic [RW-1:0] wb_addr,
                                         input logic [XLEN-1:0] wb_data);
    op_bundle_t r;
    r = b;
    if (v && wb_en && b.a_tag_v && (b.a_tag == wb_addr)) r.aval = wb_data;
    if (v && wb_en && b.b_tag_v && (b.b_tag == wb_addr)) r.bval = wb_data;
    return r;
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Upstream/downstream handshake, decoded fields, register-file view and write-back port.
interface operand_fetch_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 16,
  parameter int unsigned IMMW  = 14,
  parameter int unsigned OPCW  = 5,
  parameter int unsigned CONDW = 3
);
  localparam int unsigned RW = $clog2(NREG);

  logic                     in_valid;
  logic                     in_ready;
  logic [RW-1:0]            ra;
  logic [RW-1:0]            rb;
  logic [RW-1:0]            rc;
  logic                     imb;
  logic [IMMW-1:0]          imm;
  logic [OPCW-1:0]          opc;
  logic [CONDW-1:0]         cond;
  logic                     cmp;
  logic [(NREG-2)*XLEN-1:0] regs;
  logic [XLEN-1:0]          pc;
  logic [XLEN-1:0]          overflow;
  logic                     wb_en;
  logic [RW-1:0]            wb_addr;
  logic [XLEN-1:0]          wb_data;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [XLEN-1:0]          aval;
  logic [XLEN-1:0]          bval;
  logic [OPCW-1:0]          opc2;
  logic [RW-1:0]            rc2;
  logic [CONDW-1:0]         cond2;
  logic                     cmp2;

  modport slave (
    input  in_valid, ra, rb, rc, imb, imm, opc, cond, cmp, regs, pc, overflow,
           wb_en, wb_addr, wb_data, flush, out_ready,
    output in_ready, out_valid, aval, bval, opc2, rc2, cond2, cmp2
  );

  modport master (
    output in_valid, ra, rb, rc, imb, imm, opc, cond, cmp, regs, pc, overflow,
           wb_en, wb_addr, wb_data, flush, out_ready,
    input  in_ready, out_valid, aval, bval, opc2, rc2, cond2, cmp2
  );
endinterface

// File: rtl/operand_fetch_sel.sv
// Combinational A/B operand selection: register file, PC, overflow, extended immediate, write-back bypass.
module operand_sel
  import operand_fetch_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NREG       = 16,
  parameter int unsigned IMMW       = 14,
  parameter bit          IMM_SIGNED = 1'b1,
  localparam int unsigned SW        = $clog2(NREG)
) (
  input  logic [SW-1:0]            i_ra,
  input  logic [SW-1:0]            i_rb,
  input  logic                     i_imb,
  input  logic [IMMW-1:0]          i_imm,
  input  logic [(NREG-2)*XLEN-1:0] i_regs,
  input  logic [XLEN-1:0]          i_pc,
  input  logic [XLEN-1:0]          i_ovf,
  input  logic                     i_wb_en,
  input  logic [SW-1:0]            i_wb_addr,
  input  logic [XLEN-1:0]          i_wb_data,
  output logic [XLEN-1:0]          o_aval_c,
  output logic [XLEN-1:0]          o_bval_c,
  output logic                     o_a_gpr_c,
  output logic                     o_b_gpr_c
);
  localparam int unsigned EXTW = XLEN - IMMW;

  logic [XLEN-1:0] w_a_reg;
  logic [XLEN-1:0] w_b_reg;
  logic [XLEN-1:0] w_imm_ext;
  logic            w_a_gpr;
  logic            w_b_gpr;

  // Mux loop keeps PC/overflow indices from ever addressing past the flattened file.
  always_comb begin
    w_a_reg = '0;
    w_b_reg = '0;
    for (int i = 0; i < int'(NREG) - 2; i++) begin
      if (i_ra == SW'(i)) w_a_reg = i_regs[i*XLEN +: XLEN];
      if (i_rb == SW'(i)) w_b_reg = i_regs[i*XLEN +: XLEN];
    end
  end

  assign w_a_gpr   = (i_ra < SW'(NREG - 2));
  assign w_b_gpr   = (i_rb < SW'(NREG - 2));
  assign w_imm_ext = IMM_SIGNED ? {{EXTW{i_imm[IMMW-1]}}, i_imm} : {{EXTW{1'b0}}, i_imm};

  always_comb begin
    o_aval_c = '0;
    if (i_ra == SW'(idx_pc(NREG)))          o_aval_c = i_pc;
    else if (i_ra == SW'(idx_ovf(NREG)))    o_aval_c = i_ovf;
    else if (i_wb_en && i_wb_addr == i_ra)  o_aval_c = i_wb_data;
    else                                    o_aval_c = w_a_reg;
  end

  always_comb begin
    o_bval_c = '0;
    if (i_imb)                                       o_bval_c = w_imm_ext;
    else if (w_b_gpr && i_wb_en && i_wb_addr == i_rb) o_bval_c = i_wb_data;
    else if (w_b_gpr)                                o_bval_c = w_b_reg;
  end

  assign o_a_gpr_c = w_a_gpr;
  assign o_b_gpr_c = !i_imb && w_b_gpr;

endmodule

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: resolves operands and holds them in a 2-entry skid pair that tracks write-back.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int unsigned XLEN       = operand_fetch_pkg::XLEN,
  parameter int unsigned NREG       = operand_fetch_pkg::NREG,
  parameter int unsigned IMMW       = operand_fetch_pkg::IMMW,
  parameter bit          IMM_SIGNED = 1'b1,
  parameter int unsigned OPCW       = operand_fetch_pkg::OPCW,
  parameter int unsigned CONDW      = operand_fetch_pkg::CONDW
) (
  input logic                clk,
  input logic                rst,
  operand_fetch_if.slave     bus
);
  localparam logic [1:0] S_EMPTY = 2'b00;
  localparam logic [1:0] S_ONE   = 2'b10;
  localparam logic [1:0] S_FULL  = 2'b11;

  op_bundle_t r_out, r_skid;
  logic       r_out_v, r_skid_v;

  op_bundle_t w_in, w_out_ref, w_skid_ref, w_nxt_out, w_nxt_skid;
  logic       w_nxt_out_v, w_nxt_skid_v;
  logic [XLEN-1:0] w_aval, w_bval;
  logic       w_a_gpr, w_b_gpr;
  logic       w_in_xfer, w_out_xfer;

  operand_sel #(
    .XLEN(XLEN), .NREG(NREG), .IMMW(IMMW), .IMM_SIGNED(IMM_SIGNED)
  ) u_sel (
    .i_ra(bus.ra), .i_rb(bus.rb), .i_imb(bus.imb), .i_imm(bus.imm),
    .i_regs(bus.regs), .i_pc(bus.pc), .i_ovf(bus.overflow),
    .i_wb_en(bus.wb_en), .i_wb_addr(bus.wb_addr), .i_wb_data(bus.wb_data),
    .o_aval_c(w_aval), .o_bval_c(w_bval), .o_a_gpr_c(w_a_gpr), .o_b_gpr_c(w_b_gpr)
  );

  always_comb begin
    w_in         = '0;
    w_in.aval    = w_aval;
    w_in.bval    = w_bval;
    w_in.a_tag   = w_a_gpr ? bus.ra : '0;
    w_in.a_tag_v = w_a_gpr;
    w_in.b_tag   = w_b_gpr ? bus.rb : '0;
    w_in.b_tag_v = w_b_gpr;
    w_in.opc     = bus.opc;
    w_in.rc      = bus.rc;
    w_in.cond    = bus.cond;
    w_in.cmp     = bus.cmp;
  end

  assign w_out_ref  = refresh(r_out,  r_out_v,  bus.wb_en, bus.wb_addr, bus.wb_data);
  assign w_skid_ref = refresh(r_skid, r_skid_v, bus.wb_en, bus.wb_addr, bus.wb_data);
  assign w_in_xfer  = bus.in_valid && bus.in_ready;
  assign w_out_xfer = r_out_v && bus.out_ready;

  // Next-state: held entries always take their refreshed value unless replaced.
  always_comb begin
    w_nxt_out    = w_out_ref;
    w_nxt_skid   = w_skid_ref;
    w_nxt_out_v  = r_out_v;
    w_nxt_skid_v = r_skid_v;
    case ({r_out_v, r_skid_v})
      S_EMPTY: begin
        if (w_in_xfer) begin
          w_nxt_out   = w_in;
          w_nxt_out_v = 1'b1;
        end
      end
      S_ONE: begin
        if (w_out_xfer && w_in_xfer) begin
          w_nxt_out = w_in;
        end else if (w_out_xfer) begin
          w_nxt_out_v = 1'b0;
        end else if (w_in_xfer) begin
          w_nxt_skid   = w_in;
          w_nxt_skid_v = 1'b1;
        end
      end
      S_FULL: begin
        if (w_out_xfer) begin
          w_nxt_out    = w_skid_ref;
          w_nxt_skid_v = 1'b0;
        end
      end
      default: begin
        w_nxt_out_v  = 1'b0;
        w_nxt_skid_v = 1'b0;
      end
    endcase
    if (bus.flush) begin
      w_nxt_out_v  = 1'b0;
      w_nxt_skid_v = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out    <= '0;
      r_skid   <= '0;
      r_out_v  <= 1'b0;
      r_skid_v <= 1'b0;
    end else begin
      r_out    <= w_nxt_out;
      r_skid   <= w_nxt_skid;
      r_out_v  <= w_nxt_out_v;
      r_skid_v <= w_nxt_skid_v;
    end
  end

  assign bus.in_ready  = !r_skid_v && !rst;
  assign bus.out_valid = r_out_v;
  assign bus.aval      = r_out.aval;
  assign bus.bval      = r_out.bval;
  assign bus.opc2      = r_out.opc;
  assign bus.rc2       = r_out.rc;
  assign bus.cond2     = r_out.cond;
  assign bus.cmp2      = r_out.cmp;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed operations, stalls, write-back refresh, flush and reset.
module tb_operand_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  operand_fetch_if #(.XLEN(32), .NREG(16), .IMMW(14), .OPCW(5), .CONDW(3)) bus ();
  operand_fetch_if #(.XLEN(32), .NREG(16), .IMMW(14), .OPCW(5), .CONDW(3)) bus2 ();

  operand_fetch #(.IMM_SIGNED(1'b1)) dut  (.clk(clk), .rst(rst), .bus(bus));
  operand_fetch #(.IMM_SIGNED(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  localparam logic [31:0] PCV  = 32'hAAAA_0000;
  localparam logic [31:0] OVFV = 32'h5555_0001;

  logic [31:0] rf [14];
  for (genvar g = 0; g < 14; g++) begin : g_rf
    assign bus.regs[g*32 +: 32] = rf[g];
  end

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  opc;
    logic [3:0]  rc;
    logic [2:0]  cond;
    logic        cmp;
  } exp_t;

  exp_t q[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  // Monitor: every downstream transfer must match the oldest expected bundle.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      exp_t act, req;
      act = {bus.aval, bus.bval, bus.opc2, bus.rc2, bus.cond2, bus.cmp2};
      n_total++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_output actual=%h required=none", act);
      end else begin
        req = q.pop_front();
        if (act === req) n_pass++;
        else $display("FAIL out_bundle actual=%h required=%h", act, req);
      end
    end
  end

  task automatic send(input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc,
                      input logic imb, input logic [13:0] imm, input logic [4:0] opc,
                      input logic [2:0] cond, input logic cmp,
                      input logic [31:0] ea, input logic [31:0] eb, input bit push);
    bit acc;
    bus.in_valid = 1'b1;
    bus.ra = ra; bus.rb = rb; bus.rc = rc; bus.imb = imb; bus.imm = imm;
    bus.opc = opc; bus.cond = cond; bus.cmp = cmp;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_total++;
      $display("FAIL accept_timeout actual=no_accept required=accept");
    end else if (push) begin
      q.push_back({ea, eb, opc, rc, cond, cmp});
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wb(input logic en, input logic [3:0] addr, input logic [31:0] data);
    bus.wb_en = en; bus.wb_addr = addr; bus.wb_data = data;
  endtask

  initial begin
    for (int i = 0; i < 14; i++) rf[i] = 32'h1000_0000 + 32'(i);
    rf[3] = 32'h0000_1234;
    rf[5] = 32'h0000_0001;
    bus.in_valid = 0; bus.ra = 0; bus.rb = 0; bus.rc = 0; bus.imb = 0; bus.imm = 0;
    bus.opc = 0; bus.cond = 0; bus.cmp = 0; bus.pc = PCV; bus.overflow = OVFV;
    bus.flush = 0; bus.out_ready = 1'b1;
    wb(1'b0, 4'd0, 32'd0);
    bus2.in_valid = 0; bus2.ra = 0; bus2.rb = 0; bus2.rc = 0; bus2.imb = 1'b1; bus2.imm = 0;
    bus2.opc = 0; bus2.cond = 0; bus2.cmp = 0; bus2.regs = '0; bus2.pc = 0; bus2.overflow = 0;
    bus2.wb_en = 0; bus2.wb_addr = 0; bus2.wb_data = 0; bus2.flush = 0; bus2.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_aval", bus.aval, 32'd0);
    chk("rst_bval", bus.bval, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    // Immediate extension, signed here and unsigned in the second instance
    bus2.in_valid = 1'b1; bus2.imm = 14'h3FFF;
    send(4'd3, 4'd0, 4'd7, 1'b1, 14'h3FFF, 5'h11, 3'd3, 1'b1, 32'h0000_1234, 32'hFFFF_FFFF, 1);
    bus2.in_valid = 1'b0;
    @(negedge clk);
    chk("unsigned_imm_valid", 32'(bus2.out_valid), 32'd1);
    chk("unsigned_imm_bval", bus2.bval, 32'h0000_3FFF);
    @(posedge clk); #1;

    // Special registers
    send(4'd14, 4'd15, 4'd1, 1'b0, 14'd0, 5'h02, 3'd1, 1'b0, PCV, 32'd0, 1);
    send(4'd15, 4'd2, 4'd2, 1'b0, 14'd0, 5'h03, 3'd2, 1'b1, OVFV, 32'h1000_0002, 1);

    // Bypass on both operands; write-back to the PC index is ignored
    wb(1'b1, 4'd5, 32'd9);
    send(4'd5, 4'd5, 4'd4, 1'b0, 14'd0, 5'h04, 3'd0, 1'b0, 32'd9, 32'd9, 1);
    rf[5] = 32'd9;
    wb(1'b1, 4'd14, 32'hDEAD_BEEF);
    send(4'd14, 4'd3, 4'd5, 1'b0, 14'd0, 5'h05, 3'd4, 1'b1, PCV, 32'h0000_1234, 1);
    wb(1'b0, 4'd0, 32'd0);
    repeat (2) @(posedge clk); #1;

    // Stall with refresh of both held entries
    bus.out_ready = 1'b0;
    send(4'd1, 4'd2, 4'd6, 1'b0, 14'd0, 5'h06, 3'd5, 1'b0, 32'h0000_0055, 32'h1000_0002, 1);
    send(4'd4, 4'd6, 4'd8, 1'b0, 14'd0, 5'h07, 3'd6, 1'b1, 32'h0000_0044, 32'h0000_0077, 1);
    @(negedge clk);
    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
    wb(1'b1, 4'd6, 32'h77);
    @(posedge clk); #1;
    rf[6] = 32'h77;
    wb(1'b1, 4'd1, 32'h55);
    @(posedge clk); #1;
    rf[1] = 32'h55;
    wb(1'b0, 4'd0, 32'd0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wb(1'b1, 4'd4, 32'h44);
    @(posedge clk); #1;
    rf[4] = 32'h44;
    wb(1'b0, 4'd0, 32'd0);
    send(4'd6, 4'd8, 4'd9, 1'b0, 14'd0, 5'h08, 3'd7, 1'b0, 32'h0000_0077, 32'h1000_0008, 1);
    repeat (3) @(posedge clk); #1;

    // Flush while full drops held and incoming work
    bus.out_ready = 1'b0;
    send(4'd7, 4'd7, 4'd1, 1'b0, 14'd0, 5'h09, 3'd0, 1'b0, 32'd0, 32'd0, 0);
    send(4'd8, 4'd8, 4'd2, 1'b0, 14'd0, 5'h0A, 3'd0, 1'b0, 32'd0, 32'd0, 0);
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.ra = 4'd9;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    send(4'd9, 4'd10, 4'd3, 1'b0, 14'd0, 5'h0B, 3'd1, 1'b1, 32'h1000_0009, 32'h1000_000A, 1);
    repeat (2) @(posedge clk); #1;

    // Reset while full clears everything
    bus.out_ready = 1'b0;
    send(4'd2, 4'd3, 4'd4, 1'b0, 14'd0, 5'h1F, 3'd7, 1'b1, 32'd0, 32'd0, 0);
    send(4'd3, 4'd2, 4'd5, 1'b0, 14'd0, 5'h1E, 3'd6, 1'b1, 32'd0, 32'd0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_full_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_full_aval", bus.aval, 32'd0);
    chk("rst_full_bval", bus.bval, 32'd0);
    chk("rst_full_fields", {25'd0, bus.opc2, bus.rc2, bus.cond2, bus.cmp2}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    send(4'd11, 4'd13, 4'd6, 1'b0, 14'd0, 5'h0C, 3'd2, 1'b0, 32'h1000_000B, 32'h1000_000D, 1);
    @(negedge clk);
    chk("post_rst_latency", 32'(bus.out_valid), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
